fft_out_serializer: RTL and testbench
=====================================

FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

Interface
REQ-001 Parameter N, default 8, number of FFT bins per frame (power of two, 2..64).
REQ-002 Parameter DATA_OUT_W, default 21, signed width of each FFT output component.
REQ-003 Parameter FFT_LATENCY, default 3, clock edges from the frame_valid_i sample to valid y_re_i/y_im_i (range 1..15).
REQ-004 Port clk_i  input  1  single clock; all logic rising-edge.
REQ-005 Port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 Port frame_valid_i  input  1  one-cycle pulse, the same pulse driven to the FFT valid_i.
REQ-007 Port y_re_i  input  signed [DATA_OUT_W-1:0] x N (unpacked [0:N-1])  FFT real outputs, natural bin order.
REQ-008 Port y_im_i  input  signed [DATA_OUT_W-1:0] x N (unpacked [0:N-1])  FFT imaginary outputs.
REQ-009 Port m_valid_o  output  1  stream bin valid.
REQ-010 Port m_ready_i  input  1  downstream ready.
REQ-011 Port m_re_o  output  signed DATA_OUT_W  bin real part.
REQ-012 Port m_im_o  output  signed DATA_OUT_W  bin imaginary part.
REQ-013 Port m_idx_o  output  $clog2(N)  bin index of the current beat.
REQ-014 Port m_last_o  output  1  high on the beat with m_idx_o == N-1.
REQ-015 Port busy_o  output  1  high in WAIT or STREAM.
REQ-016 Port drop_o  output  1  one-cycle pulse when a frame_valid_i is rejected.

Function
REQ-017 States IDLE, WAIT, STREAM; the reset state SHALL be IDLE.
REQ-018 IDLE: frame_valid_i high at edge T -> WAIT, latency counter loaded so the capture occurs at edge T+FFT_LATENCY.
REQ-019 WAIT: the counter decrements each cycle; at the capture edge, all N y_re_i/y_im_i values SHALL be registered into a frame buffer, idx is cleared to 0, and the state -> STREAM.
REQ-020 STREAM: m_valid_o=1 starting the cycle after the capture; m_re_o/m_im_o = buffer[idx]; m_idx_o = idx.
REQ-021 Transfer occurs at an edge where m_valid_o && m_ready_i; idx then increments.
REQ-022 While m_valid_o && !m_ready_i, m_re_o, m_im_o, m_idx_o and m_last_o SHALL hold stable, and m_valid_o SHALL NOT deassert.
REQ-023 Transfer of beat idx==N-1 -> IDLE; m_valid_o low the next cycle unless REQ-025 applies.
REQ-024 frame_valid_i high in WAIT, or in STREAM other than on the final-transfer cycle: ignored, drop_o=1 the next cycle, and the current frame is unaffected.
REQ-025 frame_valid_i high in the same cycle as the final transfer: accepted as in REQ-018 (state -> WAIT), with no drop.
REQ-026 The buffer SHALL be loaded only at the capture edge; y inputs are don't-care at all other times.
REQ-027 No arithmetic is performed; data passes bit-exact, with sign preserved.
REQ-028 Total latency: first beat valid FFT_LATENCY+1 edges after the frame_valid_i sample; the frame completes in N beats with continuous ready.

Reset
REQ-029 rst_ni low (at any time, including mid-WAIT/STREAM) SHALL immediately force: state IDLE, counter 0, idx 0, m_valid_o 0, m_re_o 0, m_im_o 0, m_idx_o 0, m_last_o 0, busy_o 0, drop_o 0.
REQ-030 A partially streamed frame SHALL be discarded on reset; there is no resumption after release.
REQ-031 frame_valid_i sampled in the first edge after rst_ni release SHALL be accepted normally.

Verification
REQ-032 Basic frame: FFT_LATENCY=3, y_re_i[k]=k*1000, y_im_i[k]=-k, ready=1, pulse at edge 0 -> beats at edges 4..11 with idx 0..7, re 0..7000, im 0..-7, and m_last_o only at idx 7.
REQ-033 Backpressure: m_ready_i toggles 1,0,0,1,... -> each beat is held stable while ready=0, no beat is lost or duplicated, and the 8 beats arrive in order.
REQ-034 Drop: a second pulse 2 cycles after the first -> drop_o is a single-cycle pulse, and the first frame streams unchanged.
REQ-035 Back-to-back: a pulse coinciding with the idx 7 transfer -> no drop, busy_o stays 1, and the second frame's first beat is valid FFT_LATENCY+1 edges later.
REQ-036 Reset mid-stream: rst_ni low during idx 3 -> all outputs 0 asynchronously; after release, a new pulse yields a full frame starting at idx 0.
REQ-037 Signed extremes: y_re_i[5]=-2^20 and y_im_i[5]=2^20-1 -> beat 5 carries 0x100000 and 0x0FFFFF exactly.

Source files
------------

// File: rtl/fft_out_serializer.sv
// Captures one parallel FFT output frame and replays it as an N-beat
// valid/ready stream of (re, im, idx, last) beats.
module fft_out_serializer #(
    parameter int unsigned N           = 8,
    parameter int unsigned DATA_OUT_W  = 21,
    parameter int unsigned FFT_LATENCY = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         frame_valid_i,
    input  logic signed [DATA_OUT_W-1:0] y_re_i [0:N-1],
    input  logic signed [DATA_OUT_W-1:0] y_im_i [0:N-1],
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic signed [DATA_OUT_W-1:0] m_re_o,
    output logic signed [DATA_OUT_W-1:0] m_im_o,
    output logic [$clog2(N)-1:0]         m_idx_o,
    output logic                         m_last_o,
    output logic                         busy_o,
    output logic                         drop_o
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FFT_LATENCY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STREAM
    } state_t;

    state_t                        state;
    logic [CNT_W-1:0]              cnt;
    logic signed [DATA_OUT_W-1:0]  buf_re [0:N-1];
    logic signed [DATA_OUT_W-1:0]  buf_im [0:N-1];
    logic                          capture;
    logic                          last_xfer;
    logic [IDX_W-1:0]              idx_nxt;

    // Capture edge is the last WAIT cycle; final transfer ends the frame.
    assign capture   = (state == S_WAIT) && (cnt == '0);
    assign last_xfer = (state == S_STREAM) && m_ready_i && (m_idx_o == IDX_LAST);
    assign idx_nxt   = m_idx_o + IDX_W'(1);

    // Frame buffer: loaded only at the capture edge, data-path only so no reset.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            buf_re <= y_re_i;
            buf_im <= y_im_i;
        end
    end

    // Control FSM with registered stream outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            cnt       <= '0;
            m_valid_o <= 1'b0;
            m_re_o    <= '0;
            m_im_o    <= '0;
            m_idx_o   <= '0;
            m_last_o  <= 1'b0;
            busy_o    <= 1'b0;
            drop_o    <= 1'b0;
        end else begin
            drop_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_valid_i) begin
                        state  <= S_WAIT;
                        cnt    <= CNT_LOAD;
                        busy_o <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (frame_valid_i) begin
                        drop_o <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state     <= S_STREAM;
                        m_valid_o <= 1'b1;
                        m_re_o    <= y_re_i[0];
                        m_im_o    <= y_im_i[0];
                        m_idx_o   <= '0;
                        m_last_o  <= (IDX_LAST == '0);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_STREAM: begin
                    if (last_xfer) begin
                        m_valid_o <= 1'b0;
                        m_last_o  <= 1'b0;
                        if (frame_valid_i) begin
                            state <= S_WAIT;
                            cnt   <= CNT_LOAD;
                        end else begin
                            state  <= S_IDLE;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        if (frame_valid_i) begin
                            drop_o <= 1'b1;
                        end
                        if (m_ready_i) begin
                            m_idx_o  <= idx_nxt;
                            m_re_o   <= buf_re[idx_nxt];
                            m_im_o   <= buf_im[idx_nxt];
                            m_last_o <= (idx_nxt == IDX_LAST);
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    m_valid_o <= 1'b0;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer: basic frame, backpressure, drops,
// back-to-back frames, signed extremes and mid-stream reset.
module tb_fft_out_serializer;

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 21;
    localparam int unsigned L  = 3;
    localparam int unsigned IW = $clog2(N);

    logic                 clk;
    logic                 rst_n;
    logic                 fv;
    logic signed [DW-1:0] y_re [0:N-1];
    logic signed [DW-1:0] y_im [0:N-1];
    logic                 m_valid;
    logic                 m_ready;
    logic signed [DW-1:0] m_re;
    logic signed [DW-1:0] m_im;
    logic [IW-1:0]        m_idx;
    logic                 m_last;
    logic                 busy;
    logic                 drop;

    logic signed [DW-1:0] exp_re [0:N-1];
    logic signed [DW-1:0] exp_im [0:N-1];

    int n_checks = 0;
    int n_err    = 0;

    fft_out_serializer #(
        .N           (N),
        .DATA_OUT_W  (DW),
        .FFT_LATENCY (L)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .frame_valid_i (fv),
        .y_re_i        (y_re),
        .y_im_i        (y_im),
        .m_valid_o     (m_valid),
        .m_ready_i     (m_ready),
        .m_re_o        (m_re),
        .m_im_o        (m_im),
        .m_idx_o       (m_idx),
        .m_last_o      (m_last),
        .busy_o        (busy),
        .drop_o        (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(m_valid), 32'(0));
        chk({tag, "_re"},    32'(m_re),    32'(0));
        chk({tag, "_im"},    32'(m_im),    32'(0));
        chk({tag, "_idx"},   32'(m_idx),   32'(0));
        chk({tag, "_last"},  32'(m_last),  32'(0));
        chk({tag, "_busy"},  32'(busy),    32'(0));
        chk({tag, "_drop"},  32'(drop),    32'(0));
    endtask

    task automatic load_y();
        for (int k = 0; k < int'(N); k++) begin
            y_re[k] = exp_re[k];
            y_im[k] = exp_im[k];
        end
    endtask

    task automatic scramble_y();
        for (int k = 0; k < int'(N); k++) begin
            y_re[k] = ~exp_re[k];
            y_im[k] = ~exp_im[k];
        end
    endtask

    task automatic expect_beat(input int k);
        chk($sformatf("beat%0d_idx", k),  32'(m_idx),  32'(k));
        chk($sformatf("beat%0d_re", k),   32'(m_re),   32'(exp_re[k]));
        chk($sformatf("beat%0d_im", k),   32'(m_im),   32'(exp_im[k]));
        chk($sformatf("beat%0d_last", k), 32'(m_last), 32'(k == int'(N) - 1));
    endtask

    // Pulse frame_valid for one edge; returns at the negedge after that edge (cyc 0).
    task automatic pulse();
        fv = 1'b1;
        @(negedge clk);
        fv = 1'b0;
    endtask

    // Runs from cyc 0 (negedge after the accepted pulse) through the last transfer.
    task automatic stream_frame(input int drop_cyc, input bit bp, input bit b2b);
        int  cyc  = 0;
        int  expk = 0;
        int  rcnt = 0;
        bit  seen = 1'b0;
        while (expk < int'(N) && cyc < 80) begin
            fv = 1'b0;
            chk($sformatf("busy_c%0d", cyc), 32'(busy), 32'(1));
            chk($sformatf("drop_c%0d", cyc), 32'(drop), 32'(cyc == drop_cyc + 1));
            if (!seen) begin
                if (m_valid) begin
                    seen = 1'b1;
                    chk("first_beat_latency", 32'(cyc), 32'(L));
                    scramble_y();
                end
            end else begin
                chk($sformatf("valid_held_c%0d", cyc), 32'(m_valid), 32'(1));
            end
            if (m_valid) expect_beat(expk);
            m_ready = bp ? (rcnt % 3 == 0) : 1'b1;
            rcnt++;
            if (cyc == drop_cyc) fv = 1'b1;
            if (b2b && m_valid && m_ready && expk == int'(N) - 1) fv = 1'b1;
            if (m_valid && m_ready) expk++;
            @(negedge clk);
            cyc++;
        end
        fv = 1'b0;
        chk("frame_beats_done", 32'(expk), 32'(N));
    endtask

    task automatic chk_idle_after(input string tag);
        chk({tag, "_valid_low"}, 32'(m_valid), 32'(0));
        chk({tag, "_busy_low"},  32'(busy),    32'(0));
    endtask

    initial begin
        rst_n   = 1'b0;
        fv      = 1'b0;
        m_ready = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            exp_re[k] = '0;
            exp_im[k] = '0;
        end
        load_y();

        // Reset state, and frame_valid ignored while held in reset
        @(negedge clk);
        chk_zero_outputs("reset");
        fv = 1'b1;
        @(negedge clk);
        fv = 1'b0;
        chk_zero_outputs("reset_fv");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame: re=k*1000, im=-k, continuous ready
        for (int k = 0; k < int'(N); k++) begin
            exp_re[k] = DW'(k * 1000);
            exp_im[k] = DW'(-k);
        end
        load_y();
        pulse();
        stream_frame(-10, 1'b0, 1'b0);
        chk_idle_after("basic_end");

        // Backpressure with ready pattern 1,0,0,...
        for (int k = 0; k < int'(N); k++) begin
            exp_re[k] = DW'(k * 37 - 150);
            exp_im[k] = DW'(k * 4096 + 5);
        end
        load_y();
        pulse();
        stream_frame(-10, 1'b1, 1'b0);
        chk_idle_after("bp_end");
        @(negedge clk);

        // Drop while waiting on the FFT (second pulse sampled 2 edges later)
        for (int k = 0; k < int'(N); k++) begin
            exp_re[k] = DW'(-k * 2000 - 1);
            exp_im[k] = DW'(k * 11);
        end
        load_y();
        pulse();
        stream_frame(1, 1'b0, 1'b0);
        chk_idle_after("drop_wait_end");

        // Drop mid-stream plus signed extremes on bin 5
        for (int k = 0; k < int'(N); k++) begin
            exp_re[k] = DW'(k + 100);
            exp_im[k] = DW'(k - 100);
        end
        exp_re[5] = 21'h100000;
        exp_im[5] = 21'h0FFFFF;
        load_y();
        pulse();
        stream_frame(6, 1'b0, 1'b0);
        chk_idle_after("drop_stream_end");

        // Back-to-back: next pulse coincides with the idx 7 transfer
        for (int k = 0; k < int'(N); k++) begin
            exp_re[k] = DW'(k * 3);
            exp_im[k] = DW'(-k * 3);
        end
        load_y();
        pulse();
        stream_frame(-10, 1'b0, 1'b1);
        for (int k = 0; k < int'(N); k++) begin
            exp_re[k] = DW'(7 - k);
            exp_im[k] = DW'(k * 1234);
        end
        load_y();
        stream_frame(-10, 1'b0, 1'b0);
        chk_idle_after("b2b_end");

        // Reset asserted while beat idx 3 is presented
        for (int k = 0; k < int'(N); k++) begin
            exp_re[k] = DW'(k * 500);
            exp_im[k] = DW'(k * 7);
        end
        load_y();
        m_ready = 1'b1;
        pulse();
        repeat (6) @(negedge clk);
        chk("rst_pre_valid", 32'(m_valid), 32'(1));
        chk("rst_pre_idx",   32'(m_idx),   32'(3));
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("rst_async");
        @(negedge clk);
        chk_zero_outputs("rst_held");

        // Pulse sampled on the first edge after release yields a fresh frame
        for (int k = 0; k < int'(N); k++) begin
            exp_re[k] = DW'(-k * 250);
            exp_im[k] = DW'(k * 9 + 1);
        end
        load_y();
        rst_n = 1'b1;
        pulse();
        stream_frame(-10, 1'b0, 1'b0);
        chk_idle_after("post_rst_end");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
